// File: rtl/vertex_mem_responder.sv
// Vertex attribute memory responder: in-order byte-addressed line reads with
// unaligned two-line merge, fixed response latency and a priority line-write port.
module vertex_mem_responder #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_req_valid,
  input  logic [ADDR_W-1:0]          mem_req_addr,
  output logic                       mem_req_ready,
  output logic                       mem_rsp_valid,
  output logic [DATA_W-1:0]          mem_rsp_data,
  input  logic                       wr_valid,
  input  logic [$clog2(DEPTH)-1:0]   wr_line,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       busy
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned LINE_W = $clog2(DEPTH);
  localparam int unsigned IDX_W  = OFF_W + LINE_W;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SH_W   = OFF_W + 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD0  = 2'd1,
    S_RD1  = 2'd2
  } state_t;

  // Request queue: only line index and lane offset are kept (upper bits wrap).
  logic [IDX_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_c;
  logic              pop_c;
  logic              empty_c;
  logic [IDX_W-1:0]  head_c;
  logic              unused_addr_bits;

  // Engine state
  state_t            state_q;
  state_t            state_nx;
  logic [LINE_W-1:0] cur_line_q;
  logic [OFF_W-1:0]  cur_off_q;
  logic              rd_en_c;
  logic [LINE_W-1:0] rd_line_c;
  logic              cmp_c;
  logic              hi_c;

  // Array and read result
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] arr_q;
  logic [DATA_W-1:0] lo_q;
  logic              cmp_valid_q;
  logic [OFF_W-1:0]  cmp_off_q;
  logic [DATA_W-1:0] word_c;

  // Delay pipe
  logic [LATENCY-1:0] pipe_v_q;
  logic [DATA_W-1:0]  pipe_d_q [LATENCY];

  assign unused_addr_bits = ^mem_req_addr[ADDR_W-1:IDX_W];

  assign mem_req_ready = rst_n && (count_q != CNT_W'(FIFO_DEPTH));
  assign push_c        = mem_req_valid && mem_req_ready;
  assign empty_c       = (count_q == '0);
  assign head_c        = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= mem_req_addr[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_line_q <= '0;
      cur_off_q  <= '0;
    end else begin
      state_q <= state_nx;
      if (pop_c) begin
        cur_line_q <= head_c[IDX_W-1:OFF_W];
        cur_off_q  <= head_c[OFF_W-1:0];
      end
    end
  end

  // Next-state: a write cycle freezes the engine entirely.
  always_comb begin
    state_nx  = state_q;
    pop_c     = 1'b0;
    rd_en_c   = 1'b0;
    rd_line_c = cur_line_q;
    cmp_c     = 1'b0;
    hi_c      = 1'b0;
    if (!wr_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (!empty_c) begin
            pop_c    = 1'b1;
            state_nx = S_RD0;
          end
        end
        S_RD0: begin
          rd_en_c = 1'b1;
          if (cur_off_q == '0) begin
            cmp_c = 1'b1;
            if (!empty_c) begin
              pop_c    = 1'b1;
              state_nx = S_RD0;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            state_nx = S_RD1;
          end
        end
        S_RD1: begin
          rd_en_c   = 1'b1;
          rd_line_c = cur_line_q + LINE_W'(1);
          hi_c      = 1'b1;
          cmp_c     = 1'b1;
          if (!empty_c) begin
            pop_c    = 1'b1;
            state_nx = S_RD0;
          end else begin
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Vertex buffer array; contents survive reset. Reads never coincide with writes.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      mem_q[wr_line] <= wr_data;
    end
    if (rd_en_c) begin
      arr_q <= mem_q[rd_line_c];
    end
    if (hi_c) begin
      lo_q <= arr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_valid_q <= 1'b0;
      cmp_off_q   <= '0;
    end else begin
      cmp_valid_q <= cmp_c;
      if (cmp_c) begin
        cmp_off_q <= cur_off_q;
      end
    end
  end

  // Unaligned merge: upper lanes of line L followed by lower lanes of line L+1.
  always_comb begin
    word_c = arr_q;
    if (cmp_off_q != '0) begin
      word_c = DATA_W'({arr_q, lo_q} >> {cmp_off_q, 3'b000});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_v_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_d_q[i] <= '0;
      end
    end else begin
      pipe_v_q[0] <= cmp_valid_q;
      if (cmp_valid_q) begin
        pipe_d_q[0] <= word_c;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        if (pipe_v_q[i-1]) begin
          pipe_d_q[i] <= pipe_d_q[i-1];
        end
      end
    end
  end

  assign mem_rsp_valid = pipe_v_q[LATENCY-1];
  assign mem_rsp_data  = pipe_d_q[LATENCY-1];
  assign busy = !empty_c || (state_q != S_IDLE) || cmp_valid_q || (|pipe_v_q);

  localparam int unsigned UNUSED_SH_W = SH_W;

endmodule
